// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM states, owner ids, write payload.
// Build option: ARB_RR_EN selects round-robin arbitration (default fixed, LSU first).
package ram_arb_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned UP_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        WR    = 2'd2,
        WRESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    // Write payload latched at grant and driven onto the RAM write channel.
    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] wmask;
    } wr_payload_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of IFU / LSU request channels and the shared RAM port.
// slave  : arbiter view (takes requests, drives the RAM port).
// master : environment view (core requesters plus RAM).
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    // Instruction fetch (read-only)
    logic                  ifu_req_i;
    logic [UP_ADDR_W-1:0]  ifu_addr_i;
    logic [DATA_W-1:0]     ifu_rdata_o;
    logic                  ifu_done_o;

    // Load / store
    logic                  lsu_req_i;
    logic                  lsu_we_i;
    logic [UP_ADDR_W-1:0]  lsu_addr_i;
    logic [DATA_W-1:0]     lsu_wdata_i;
    logic [DATA_W-1:0]     lsu_wmask_i;
    logic [DATA_W-1:0]     lsu_rdata_o;
    logic                  lsu_done_o;

    // Status
    logic                  err_o;
    logic                  busy_o;

    // RAM read channel
    logic                  ram_ren_o;
    logic [ADDR_W-1:0]     ram_raddr_o;
    logic                  ram_rready_i;
    logic [DATA_W-1:0]     ram_rdata_i;

    // RAM write channel and response
    logic                  ram_wen_o;
    logic [ADDR_W-1:0]     ram_waddr_o;
    logic [DATA_W-1:0]     ram_wdata_o;
    logic [DATA_W-1:0]     ram_wmask_o;
    logic                  ram_wready_i;
    logic                  ram_bvalid_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        output ifu_rdata_o, ifu_done_o,
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
        output lsu_rdata_o, lsu_done_o,
        output err_o, busy_o,
        output ram_ren_o, ram_raddr_o,
        input  ram_rready_i, ram_rdata_i,
        output ram_wen_o, ram_waddr_o, ram_wdata_o, ram_wmask_o,
        input  ram_wready_i, ram_bvalid_i
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        input  ifu_rdata_o, ifu_done_o,
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
        input  lsu_rdata_o, lsu_done_o,
        input  err_o, busy_o,
        input  ram_ren_o, ram_raddr_o,
        output ram_rready_i, ram_rdata_i,
        input  ram_wen_o, ram_waddr_o, ram_wdata_o, ram_wmask_o,
        output ram_wready_i, ram_bvalid_i
    );

endinterface

// File: rtl/ram_port_arbiter_arb_grant.sv
// Combinational one-hot grant between IFU and LSU.
// Ports: i_*_req requests, i_*_mask suppress a requester (its done cycle),
//        i_rr_pri (ARB_RR_EN only) tie winner, o_*_gnt_c grant outputs.
// ARB_RR_EN defined: ties go to i_rr_pri; undefined: LSU always wins ties.
module arb_grant
    import ram_arb_pkg::*;
(
    input  logic   i_ifu_req,
    input  logic   i_lsu_req,
    input  logic   i_ifu_mask,
    input  logic   i_lsu_mask,
`ifdef ARB_RR_EN
    input  owner_e i_rr_pri,
`endif
    output logic   o_ifu_gnt_c,
    output logic   o_lsu_gnt_c
);

    logic w_ifu_req;
    logic w_lsu_req;

    // A requester that is just receiving done still shows its stale req.
    assign w_ifu_req = i_ifu_req & ~i_ifu_mask;
    assign w_lsu_req = i_lsu_req & ~i_lsu_mask;

`ifdef ARB_RR_EN
    assign o_lsu_gnt_c = w_lsu_req & (~w_ifu_req | (i_rr_pri == OWN_LSU));
`else
    // The older instruction (load/store) wins over fetch.
    assign o_lsu_gnt_c = w_lsu_req;
`endif
    assign o_ifu_gnt_c = w_ifu_req & ~o_lsu_gnt_c;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between instruction fetch (read) and load/store (read/write),
// one transaction at a time, with registered done pulses and a timeout bus error.
// Ports: clk, rst (sync, active high), bus (ram_port_arbiter_if.slave).
// Parameters: ADDR_W RAM address width, TIMEOUT max wait cycles (0 = never).
// Build option: ARB_RR_EN enables round-robin arbitration.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          TO_EN   = (TIMEOUT != 0);

    state_e              r_state,     w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
    owner_e              r_owner,     w_owner_nxt;
    logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
    wr_payload_t         r_wr,        w_wr_nxt;
    logic [DATA_W-1:0]   r_ifu_rdata, w_ifu_rdata_nxt;
    logic [DATA_W-1:0]   r_lsu_rdata, w_lsu_rdata_nxt;
    logic                r_ifu_done,  w_ifu_done_nxt;
    logic                r_lsu_done,  w_lsu_done_nxt;
    logic                r_err,       w_err_nxt;
    logic                r_ren;
    logic                r_wen;
    logic                r_busy;

    logic                w_ifu_gnt_c;
    logic                w_lsu_gnt_c;
    logic                w_to_hit;
    logic                w_fin;
    logic                w_fin_err;
    logic                w_fin_rd;
    logic [DATA_W-1:0]   w_fin_data;

`ifdef ARB_RR_EN
    owner_e              r_rr_pri,    w_rr_pri_nxt;
`endif

    // Requester selection; only consulted in IDLE.
    arb_grant u_arb_grant (
        .i_ifu_req   (bus.ifu_req_i),
        .i_lsu_req   (bus.lsu_req_i),
        .i_ifu_mask  (r_ifu_done),
        .i_lsu_mask  (r_lsu_done),
`ifdef ARB_RR_EN
        .i_rr_pri    (r_rr_pri),
`endif
        .o_ifu_gnt_c (w_ifu_gnt_c),
        .o_lsu_gnt_c (w_lsu_gnt_c)
    );

    // This cycle is the last allowed wait cycle.
    assign w_to_hit = TO_EN && (r_cnt >= CNT_W'(TO_LAST));

    // Next-state, latches and completion decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_owner_nxt     = r_owner;
        w_addr_nxt      = r_addr;
        w_wr_nxt        = r_wr;
        w_ifu_rdata_nxt = r_ifu_rdata;
        w_lsu_rdata_nxt = r_lsu_rdata;
        w_ifu_done_nxt  = 1'b0;
        w_lsu_done_nxt  = 1'b0;
        w_err_nxt       = 1'b0;
        w_fin           = 1'b0;
        w_fin_err       = 1'b0;
        w_fin_rd        = 1'b0;
        w_fin_data      = '0;
`ifdef ARB_RR_EN
        w_rr_pri_nxt    = r_rr_pri;
`endif

        case (r_state)
            IDLE: begin
                if (w_lsu_gnt_c) begin
                    w_state_nxt = bus.lsu_we_i ? WR : RD;
                    w_owner_nxt = OWN_LSU;
                    w_addr_nxt  = bus.lsu_addr_i[ADDR_W-1:0];
                    w_wr_nxt    = '{wdata: bus.lsu_wdata_i, wmask: bus.lsu_wmask_i};
                    w_cnt_nxt   = '0;
`ifdef ARB_RR_EN
                    w_rr_pri_nxt = OWN_IFU;
`endif
                end else if (w_ifu_gnt_c) begin
                    w_state_nxt = RD;
                    w_owner_nxt = OWN_IFU;
                    w_addr_nxt  = bus.ifu_addr_i[ADDR_W-1:0];
                    w_cnt_nxt   = '0;
`ifdef ARB_RR_EN
                    w_rr_pri_nxt = OWN_LSU;
`endif
                end
            end
            RD: begin
                if (bus.ram_rready_i) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                    w_fin_rd    = 1'b1;
                    w_fin_data  = bus.ram_rdata_i;
                end else if (w_to_hit) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                    w_fin_rd    = 1'b1;
                    w_fin_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WR: begin
                if (bus.ram_wready_i && bus.ram_bvalid_i) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                end else if (bus.ram_wready_i) begin
                    // Timeout budget spans WR and WRESP together.
                    w_state_nxt = WRESP;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end else if (w_to_hit) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                    w_fin_rd    = 1'b1;
                    w_fin_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            WRESP: begin
                if (bus.ram_bvalid_i) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                end else if (w_to_hit) begin
                    w_state_nxt = IDLE;
                    w_fin       = 1'b1;
                    w_fin_rd    = 1'b1;
                    w_fin_err   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Route completion to the owner only; timeouts return zero data.
        if (w_fin) begin
            w_err_nxt = w_fin_err;
            if (r_owner == OWN_IFU) begin
                w_ifu_done_nxt = 1'b1;
                if (w_fin_rd) w_ifu_rdata_nxt = w_fin_data;
            end else begin
                w_lsu_done_nxt = 1'b1;
                if (w_fin_rd) w_lsu_rdata_nxt = w_fin_data;
            end
        end
    end

    // State, latches and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner     <= OWN_IFU;
            r_addr      <= '0;
            r_wr        <= '0;
            r_ifu_rdata <= '0;
            r_lsu_rdata <= '0;
            r_ifu_done  <= 1'b0;
            r_lsu_done  <= 1'b0;
            r_err       <= 1'b0;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ARB_RR_EN
            r_rr_pri    <= OWN_LSU;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner     <= w_owner_nxt;
            r_addr      <= w_addr_nxt;
            r_wr        <= w_wr_nxt;
            r_ifu_rdata <= w_ifu_rdata_nxt;
            r_lsu_rdata <= w_lsu_rdata_nxt;
            r_ifu_done  <= w_ifu_done_nxt;
            r_lsu_done  <= w_lsu_done_nxt;
            r_err       <= w_err_nxt;
            r_ren       <= (w_state_nxt == RD);
            r_wen       <= (w_state_nxt == WR);
            r_busy      <= (w_state_nxt != IDLE);
`ifdef ARB_RR_EN
            r_rr_pri    <= w_rr_pri_nxt;
`endif
        end
    end

    // Upper upstream address bits are intentionally dropped.
    if (ADDR_W < UP_ADDR_W) begin : g_addr_trunc
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^{bus.ifu_addr_i[UP_ADDR_W-1:ADDR_W],
                                    bus.lsu_addr_i[UP_ADDR_W-1:ADDR_W]};
    end

    assign bus.ifu_rdata_o = r_ifu_rdata;
    assign bus.ifu_done_o  = r_ifu_done;
    assign bus.lsu_rdata_o = r_lsu_rdata;
    assign bus.lsu_done_o  = r_lsu_done;
    assign bus.err_o       = r_err;
    assign bus.busy_o      = r_busy;
    assign bus.ram_ren_o   = r_ren;
    assign bus.ram_raddr_o = r_addr;
    assign bus.ram_wen_o   = r_wen;
    assign bus.ram_waddr_o = r_addr;
    assign bus.ram_wdata_o = r_wr.wdata;
    assign bus.ram_wmask_o = r_wr.wmask;

endmodule
